// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared state encoding and width constants for the multiplier/divider pair
package seq_divider_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEF_DW = 16;
  localparam int DEF_VW = 8;
  localparam int CNT_W = $clog2(DEF_DW);
  function automatic int cnt_w(input int dw);
    return $clog2(dw);
  endfunction
endpackage

// File: rtl/seq_divider_div_step.sv
// seq_divider_div_step: one combinational restoring-division step
module seq_divider_div_step #(
  parameter int VW = 8
) (
  input  logic [VW:0]   i_rem,
  input  logic          i_msb,
  input  logic [VW-1:0] i_div,
  output logic [VW:0]   o_rem,
  output logic          o_qbit
);
  logic [VW:0] w_t;
  logic [VW:0] w_d;
  assign w_t = {i_rem[VW-1:0], i_msb};
  assign w_d = {1'b0, i_div};
  // The partial remainder never exceeds VW bits; its top bit only guards the compare.
  assign o_qbit = i_rem[VW] | (w_t >= w_d);
  assign o_rem = o_qbit ? w_t - w_d : w_t;
endmodule

// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, one quotient bit per clock,
// with a start/ready/done handshake and divide-by-zero shortcut.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero
);
  localparam int CW = cnt_w(DW);
  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [VW:0]   r_rem;
  logic [DW-1:0] r_q;
  logic [VW-1:0] r_div;
  logic [VW:0]   w_rem;
  logic          w_qbit;
  logic          w_last;
  seq_divider_div_step #(.VW(VW)) u_step (
    .i_rem (r_rem),
    .i_msb (r_q[DW-1]),
    .i_div (r_div),
    .o_rem (w_rem),
    .o_qbit(w_qbit)
  );
  assign w_last = r_cnt == CW'(DW - 1);
  always_comb begin
    w_next = IDLE;
    w_next = r_state == IDLE ? (start ? (divisor == '0 ? DONE : RUN) : IDLE) :
             r_state == RUN  ? (w_last ? DONE : RUN) : IDLE;
  end
  // Handshake flags are registered from the next state so they carry no input-to-output path.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_q       <= '0;
      r_div     <= '0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      r_state <= w_next;
      ready   <= w_next == IDLE;
      busy    <= w_next == RUN;
      done    <= w_next == DONE;
      if (r_state == IDLE && start) begin
        if (divisor == '0) begin
          quotient  <= '1;
          remainder <= dividend[VW-1:0];
          div_zero  <= 1'b1;
        end else begin
          r_q      <= dividend;
          r_rem    <= '0;
          r_div    <= divisor;
          r_cnt    <= '0;
          div_zero <= 1'b0;
        end
      end
      if (r_state == RUN) begin
        r_rem <= w_rem;
        r_q   <= {r_q[DW-2:0], w_qbit};
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          quotient  <= {r_q[DW-2:0], w_qbit};
          remainder <= w_rem[VW-1:0];
        end
      end
    end
  end
endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential restoring divider that computes quotient and remainder of a DW-bit unsigned dividend by a VW-bit unsigned divisor, one quotient bit per clock. It is the inverse companion of the combinational array multiplier in the modular-exponentiation datapath. It reduces DW-bit products modulo a VW-bit modulus and also serves as a general divide unit. A start/ready/done handshake brackets each operation.

## Interface
- DW, 16, dividend and quotient width (≥ 2)
- VW, 8, divisor and remainder width (≥ 1, ≤ DW)
- clk  input  1  rising-edge clock; single clock domain
- rst  input  1  synchronous reset, active-high
- start  input  1  request; accepted only when ready=1
- dividend  input  DW  unsigned dividend; sampled on the accepting edge
- divisor  input  VW  unsigned divisor; sampled on the accepting edge
- ready  output  1  block idle; start will be accepted
- busy  output  1  iteration in progress
- done  output  1  single-cycle pulse; results valid
- quotient  output  DW  unsigned quotient
- remainder  output  VW  unsigned remainder
- div_zero  output  1  last accepted divisor was zero

## Operation
- States:
  - IDLE: ready=1. start=1 with divisor≠0 latches the operands, clears the counter and goes to RUN. start=1 with divisor=0 goes directly to DONE.
  - RUN: busy=1. Each edge performs one restoring step. The counter runs 0..DW-1. On the edge where the counter is DW-1, the state goes to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Restoring step, with a VW+1-bit partial remainder R and a DW-bit shift register Q (initially Q=dividend, R=0):
  - T = {R[VW-1:0], Q[DW-1]}
  - If T ≥ {1'b0, divisor}: R ← T − divisor, and shift 1 into Q.
  - Otherwise: R ← T, and shift 0 into Q.
  - Q shifts left, new bit at the LSB.
- Results:
  - quotient = Q and remainder = R[VW-1:0], both updated when entering DONE.
  - The remainder is always < divisor, so VW bits suffice.
- Divide by zero: quotient = all ones, remainder = dividend[VW-1:0], div_zero=1.
- div_zero is cleared on every accepted start with a nonzero divisor.
- Results are held stable from DONE until the next accepted start. They are not cleared on return to IDLE.
- start while busy or done: ignored, no queuing. Operand changes during RUN have no effect.
- Reset, including in the middle of an operation: state IDLE, ready=1, busy=0, done=0, quotient=0, remainder=0, div_zero=0, counter=0. The aborted operation produces no done.

## Timing
- Accepting edge is edge k (start=1, ready=1). ready falls and busy rises after edge k.
- Nonzero divisor:
  - Iterations occur on edges k+1 .. k+DW.
  - done=1 and results valid during the cycle after edge k+DW. Latency is DW+1 cycles from the start edge to done (17 at defaults).
  - busy falls when done rises. ready rises after edge k+DW+1.
- Zero divisor: done=1 during the cycle after edge k; ready returns after edge k+1.
- Back-to-back throughput is one operation every DW+2 cycles, because start is first accepted at edge k+DW+2.
- ready, busy and done are mutually exclusive and are all registered outputs (no combinational path from inputs).

## Structure
- Shared package holds:
  - the state enum (IDLE, RUN, DONE)
  - default DW/VW constants used by the multiplier and divider pair
  - the counter width constant $clog2(DW)
- One sub-module, div_step: purely combinational, takes (R, Q msb, divisor) and returns (next R, quotient bit). It is instantiated once.
- The top module holds the FSM, counter, R/Q registers and output registers.

## Test plan
- dividend=100, divisor=7, start at edge k:
  - done exactly during the cycle after edge k+16
  - quotient=14, remainder=2, div_zero=0
- Full-range case: 65535/255 → quotient=257, remainder=0. 255/65535 is not applicable (VW=8); use 254/255 → quotient=0, remainder=254.
- Divide by zero: 1234/0 → done during the cycle after edge k, quotient=16'hFFFF, remainder=8'hD2, div_zero=1. A following 10/3 → quotient=3, remainder=1, div_zero=0.
- Ignored starts:
  - start held high through RUN with operands changed to 50/5 → first result still 100/7.
  - The next accepted start is at edge k+18 → second done is at the cycle after k+34.
- Reset at iteration 8 of 100/7:
  - all outputs reach their reset values after the reset edge, and no done follows
  - a new 9/4 then gives quotient=2, remainder=1
- Random sweep: 10k random (dividend, divisor≠0) pairs checked against / and % with exact 17-cycle latency; results stay stable until the next accepted start.
